// File: rtl/vect_pkg.sv
// Instruction fields, funct6/funct3 encodings and decode for the slide unit.
// SLDU_SLIDE1_EN adds vslide1up/vslide1down decode.
package vect_pkg;

   typedef struct packed {
      logic [5:0] funct6;
      logic       vm;
      logic [4:0] vs2;
      logic [4:0] vs1;
      logic [2:0] funct3;
      logic [4:0] vd;
      logic [6:0] opcode;
   } arithm_instr_t;

   localparam logic [6:0] OP_V = 7'b1010111;

   localparam logic [5:0] VADD_VREDSUM   = 6'b000000;
   localparam logic [5:0] VREDAND        = 6'b000001;
   localparam logic [5:0] VSUB_VREDOR    = 6'b000010;
   localparam logic [5:0] VRSUB_VREDXOR  = 6'b000011;
   localparam logic [5:0] VMINU_VREDMINU = 6'b000100;
   localparam logic [5:0] VMIN_VREDMIN   = 6'b000101;
   localparam logic [5:0] VMAXU_VREDMAXU = 6'b000110;
   localparam logic [5:0] VMAX_VREDMAX   = 6'b000111;
   localparam logic [5:0] VSLIDEUP       = 6'b001110;
   localparam logic [5:0] VSLIDEDOWN     = 6'b001111;
   localparam logic [5:0] VADC           = 6'b010000;

   localparam logic [2:0] OPIVV = 3'b000;
   localparam logic [2:0] OPFVV = 3'b001;
   localparam logic [2:0] OPMVV = 3'b010;
   localparam logic [2:0] OPIVI = 3'b011;
   localparam logic [2:0] OPIVX = 3'b100;
   localparam logic [2:0] OPFVF = 3'b101;
   localparam logic [2:0] OPMVX = 3'b110;

   typedef enum logic [2:0] {K_NOP, K_UP, K_DOWN, K_RED, K_MVXS, K_MVSX} op_kind_e;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_RED_WB} sldu_state_e;

   function automatic op_kind_e sldu_decode(arithm_instr_t ins);
      op_kind_e k;
      k = K_NOP;
      if (ins.opcode == OP_V) begin
         if ((ins.funct3 == OPIVX || ins.funct3 == OPIVI) && ins.funct6 == VSLIDEUP)
            k = K_UP;
         else if ((ins.funct3 == OPIVX || ins.funct3 == OPIVI) && ins.funct6 == VSLIDEDOWN)
            k = K_DOWN;
         else if (ins.funct3 == OPMVV && ins.funct6[5:3] == 3'b000)
            k = K_RED;
         else if (ins.funct3 == OPMVV && ins.funct6 == VADC)
            k = K_MVXS;
         else if (ins.funct3 == OPMVX && ins.funct6 == VADC)
            k = K_MVSX;
`ifdef SLDU_SLIDE1_EN
         else if (ins.funct3 == OPMVX && ins.funct6 == VSLIDEUP)
            k = K_UP;
         else if (ins.funct3 == OPMVX && ins.funct6 == VSLIDEDOWN)
            k = K_DOWN;
`endif
      end
      return k;
   endfunction

endpackage

// File: rtl/sldu_red_alu.sv
// Combinational binary reduction operator; op is funct6[2:0] of the reduction.
module sldu_red_alu
   import vect_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]            op_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH-1:0] res_o
);

   always_comb begin
      res_o = a_i + b_i;
      case (op_i)
         VREDAND[2:0]:        res_o = a_i & b_i;
         VSUB_VREDOR[2:0]:    res_o = a_i | b_i;
         VRSUB_VREDXOR[2:0]:  res_o = a_i ^ b_i;
         VMINU_VREDMINU[2:0]: res_o = (a_i < b_i) ? a_i : b_i;
         VMIN_VREDMIN[2:0]:   res_o = ($signed(a_i) < $signed(b_i)) ? a_i : b_i;
         VMAXU_VREDMAXU[2:0]: res_o = (a_i > b_i) ? a_i : b_i;
         VMAX_VREDMAX[2:0]:   res_o = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;
         default:             res_o = a_i + b_i;
      endcase
   end

endmodule

// File: rtl/slide_unit.sv
// Cross-lane slide/reduction/move engine: one destination element per lane per RUN cycle.
// Defining SLDU_SLIDE1_EN enables vslide1up/vslide1down (scalar inserted at the slide edge).
module slide_unit
   import vect_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int LANES      = 4,
   parameter  int VLEN       = 512,
   localparam int ELEMS      = VLEN / (DATA_WIDTH * LANES),
   localparam int ELEM_B     = $clog2(ELEMS)
) (
   input  logic                        clk_i,
   input  logic                        resetn_i,
   input  logic                        req_i,
   input  logic [31:0]                 instr_i,
   output logic                        ready_o,
   input  logic [DATA_WIDTH-1:0]       rs1_rdata_i,
   output logic [DATA_WIDTH-1:0]       rd_wdata_o,
   output logic                        rd_wr_en_o,
   input  logic [LANES*DATA_WIDTH-1:0] lane_vs1_rdata_i,
   input  logic [LANES*DATA_WIDTH-1:0] lane_vs2_rdata_i,
   input  logic [31:0]                 lane_mask_rdata_i,
   output logic [LANES*DATA_WIDTH-1:0] lane_vd_wdata_o,
   output logic [LANES-1:0]            lane_vd_wr_en_o,
   output logic [LANES*ELEM_B-1:0]     lane_vs2_elem_sel_o,
   output logic [LANES*ELEM_B-1:0]     lane_vd_elem_sel_o
);

   localparam int VLMAX  = LANES * ELEMS;
   localparam int LANE_B = $clog2(LANES);
   localparam int IDX_B  = $clog2(VLMAX);
   localparam int IDXW   = DATA_WIDTH + 1;

   arithm_instr_t         ins;
   sldu_state_e           state_q;
   op_kind_e              kind_q;
   logic [ELEM_B-1:0]     k_q;
   logic [DATA_WIDTH-1:0] off_q, rs1_q, acc_q, acc_d;
   logic                  vm_q;
   logic [2:0]            red_op_q;
   logic [LANES-1:0]      red_act;
   logic                  last_k, multi;
`ifdef SLDU_SLIDE1_EN
   logic                  s1_d, s1_q;
   assign s1_d = (ins.funct3 == OPMVX) && (sldu_decode(ins) inside {K_UP, K_DOWN});
`endif

   assign ins     = instr_i;
   assign ready_o = (state_q == S_IDLE);
   assign last_k  = (k_q == ELEM_B'(ELEMS - 1));
   assign multi   = (kind_q inside {K_UP, K_DOWN, K_RED});

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q  <= S_IDLE;
         kind_q   <= K_NOP;
         k_q      <= '0;
         off_q    <= '0;
         rs1_q    <= '0;
         acc_q    <= '0;
         vm_q     <= 1'b1;
         red_op_q <= '0;
`ifdef SLDU_SLIDE1_EN
         s1_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: if (req_i) begin
               kind_q   <= sldu_decode(ins);
               vm_q     <= ins.vm;
               red_op_q <= ins.funct6[2:0];
               rs1_q    <= rs1_rdata_i;
               off_q    <= rs1_rdata_i;
               k_q      <= '0;
               state_q  <= S_RUN;
`ifdef SLDU_SLIDE1_EN
               s1_q     <= s1_d;
               if (s1_d) off_q <= DATA_WIDTH'(1);
`endif
            end
            S_RUN: begin
               if (kind_q == K_RED) acc_q <= acc_d;
               if (multi && !last_k) begin
                  k_q <= k_q + 1'b1;
               end else begin
                  k_q     <= '0;
                  state_q <= (kind_q == K_RED) ? S_RED_WB : S_IDLE;
               end
            end
            S_RED_WB: state_q <= S_IDLE;
            default:  state_q <= S_IDLE;
         endcase
      end
   end

   // Lane l owns destination d = k*LANES + l; its source may sit in any lane.
   always_comb begin
      logic [IDXW-1:0]       d, s;
      logic                  src_ok, src_zero, act, we;
      logic [DATA_WIDTH-1:0] wd;
      lane_vd_wdata_o     = '0;
      lane_vd_wr_en_o     = '0;
      lane_vs2_elem_sel_o = '0;
      lane_vd_elem_sel_o  = '0;
      rd_wdata_o          = '0;
      rd_wr_en_o          = 1'b0;
      red_act             = '0;
      d = '0; s = '0; src_ok = 1'b0; src_zero = 1'b0; act = 1'b0; we = 1'b0; wd = '0;
      for (int l = 0; l < LANES; l++) begin
         d        = (IDXW'(k_q) << LANE_B) + IDXW'(l);
         act      = vm_q | lane_mask_rdata_i[d[IDX_B-1:0]];
         src_ok   = 1'b1;
         src_zero = 1'b0;
         if (kind_q == K_UP) begin
            src_ok = (d >= {1'b0, off_q});
            s      = d - {1'b0, off_q};
         end else begin
            s        = d + {1'b0, off_q};
            src_zero = (s >= IDXW'(VLMAX));
         end
         red_act[l] = act;
         if (state_q == S_RUN && (kind_q == K_UP || kind_q == K_DOWN)) begin
            wd = '0;
            if (src_ok && !src_zero) begin
               lane_vs2_elem_sel_o[s[LANE_B-1:0]*ELEM_B +: ELEM_B] = s[LANE_B +: ELEM_B];
               wd = lane_vs2_rdata_i[s[LANE_B-1:0]*DATA_WIDTH +: DATA_WIDTH];
            end
            we = act && src_ok;
`ifdef SLDU_SLIDE1_EN
            if (s1_q && kind_q == K_UP && d == '0) begin
               we = act;
               wd = rs1_q;
            end
            if (s1_q && kind_q == K_DOWN && d == IDXW'(VLMAX - 1)) wd = rs1_q;
`endif
            lane_vd_elem_sel_o[l*ELEM_B +: ELEM_B]   = k_q;
            lane_vd_wdata_o[l*DATA_WIDTH +: DATA_WIDTH] = wd;
            lane_vd_wr_en_o[l]                        = we;
         end
      end
      if (state_q == S_RUN) begin
         case (kind_q)
            K_RED: for (int l = 0; l < LANES; l++) lane_vs2_elem_sel_o[l*ELEM_B +: ELEM_B] = k_q;
            K_MVXS: begin
               rd_wdata_o = lane_vs2_rdata_i[DATA_WIDTH-1:0];
               rd_wr_en_o = 1'b1;
            end
            K_MVSX: begin
               lane_vd_wdata_o[DATA_WIDTH-1:0] = rs1_q;
               lane_vd_wr_en_o[0]              = 1'b1;
            end
            default: ;
         endcase
      end else if (state_q == S_RED_WB) begin
         lane_vd_wdata_o[DATA_WIDTH-1:0] = acc_q;
         lane_vd_wr_en_o[0]              = 1'b1;
      end
   end

   // Reduction chain folds lanes 0..LANES-1 in order; masked-off lanes pass through.
   for (genvar l = 0; l < LANES; l++) begin : g_red
      logic [DATA_WIDTH-1:0] a_in, alu_res, acc_out;
      if (l == 0) begin : g_first
         assign a_in = (k_q == '0) ? lane_vs1_rdata_i[DATA_WIDTH-1:0] : acc_q;
      end else begin : g_next
         assign a_in = g_red[l-1].acc_out;
      end
      sldu_red_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
         .op_i  (red_op_q),
         .a_i   (a_in),
         .b_i   (lane_vs2_rdata_i[l*DATA_WIDTH +: DATA_WIDTH]),
         .res_o (alu_res)
      );
      assign acc_out = red_act[l] ? alu_res : a_in;
   end
   assign acc_d = g_red[LANES-1].acc_out;

   logic unused_bits;
   assign unused_bits = ^{ins.vs2, ins.vs1, ins.vd, lane_mask_rdata_i[31:VLMAX],
                          lane_vs1_rdata_i[LANES*DATA_WIDTH-1:DATA_WIDTH]};

endmodule

// File: tb/tb_slide_unit.sv
// Directed bench for slide_unit with a behavioural 4-lane register file around it.
module tb_slide_unit;
   localparam int DW = 32;
   localparam int L  = 4;
   localparam int EB = 2;
   localparam int N  = 16;

   logic          clk_i = 1'b0;
   logic          resetn_i;
   logic          req_i;
   logic [31:0]   instr_i;
   logic          ready_o;
   logic [31:0]   rs1_rdata_i;
   logic [31:0]   rd_wdata_o;
   logic          rd_wr_en_o;
   logic [L*DW-1:0] lane_vs1_rdata_i;
   logic [L*DW-1:0] lane_vs2_rdata_i;
   logic [31:0]   lane_mask_rdata_i;
   logic [L*DW-1:0] lane_vd_wdata_o;
   logic [L-1:0]  lane_vd_wr_en_o;
   logic [L*EB-1:0] lane_vs2_elem_sel_o;
   logic [L*EB-1:0] lane_vd_elem_sel_o;

   logic [31:0] vs1_mem [N];
   logic [31:0] vs2_mem [N];
   logic [31:0] vd_mem  [N];
   logic        clr_req;

   int total = 0;
   int bad   = 0;
   int busy, rd_cnt;
   logic [31:0] rd_val;

   always #5 clk_i = ~clk_i;

   slide_unit dut (
      .clk_i               (clk_i),
      .resetn_i            (resetn_i),
      .req_i               (req_i),
      .instr_i             (instr_i),
      .ready_o             (ready_o),
      .rs1_rdata_i         (rs1_rdata_i),
      .rd_wdata_o          (rd_wdata_o),
      .rd_wr_en_o          (rd_wr_en_o),
      .lane_vs1_rdata_i    (lane_vs1_rdata_i),
      .lane_vs2_rdata_i    (lane_vs2_rdata_i),
      .lane_mask_rdata_i   (lane_mask_rdata_i),
      .lane_vd_wdata_o     (lane_vd_wdata_o),
      .lane_vd_wr_en_o     (lane_vd_wr_en_o),
      .lane_vs2_elem_sel_o (lane_vs2_elem_sel_o),
      .lane_vd_elem_sel_o  (lane_vd_elem_sel_o)
   );

   always_comb begin
      lane_vs1_rdata_i = '0;
      lane_vs2_rdata_i = '0;
      for (int l = 0; l < L; l++) begin
         lane_vs2_rdata_i[l*DW +: DW] = vs2_mem[int'(lane_vs2_elem_sel_o[l*EB +: EB])*L + l];
         lane_vs1_rdata_i[l*DW +: DW] = vs1_mem[int'(lane_vs2_elem_sel_o[l*EB +: EB])*L + l];
      end
   end

   always @(posedge clk_i) begin
      if (clr_req) begin
         for (int i = 0; i < N; i++) vd_mem[i] <= 32'hA5A50000 + 32'(i);
      end else begin
         for (int l = 0; l < L; l++)
            if (lane_vd_wr_en_o[l])
               vd_mem[int'(lane_vd_elem_sel_o[l*EB +: EB])*L + l] <= lane_vd_wdata_o[l*DW +: DW];
      end
   end

   function automatic logic [31:0] sent(int i);
      return 32'hA5A50000 + 32'(i);
   endfunction

   function automatic logic [31:0] mk(logic [5:0] f6, logic vm, logic [2:0] f3, logic [4:0] rs1f);
      return {f6, vm, 5'd8, rs1f, f3, 5'd4, 7'b1010111};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_vd();
      @(negedge clk_i) clr_req = 1'b1;
      @(negedge clk_i) clr_req = 1'b0;
   endtask

   task automatic run_op(input logic [31:0] ins, input logic [31:0] rs1);
      @(negedge clk_i);
      instr_i = ins; rs1_rdata_i = rs1; req_i = 1'b1;
      @(posedge clk_i);
      #1 req_i = 1'b0;
      busy = 0; rd_cnt = 0; rd_val = '0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk_i);
         if (ready_o) break;
         busy++;
         if (rd_wr_en_o) begin rd_cnt++; rd_val = rd_wdata_o; end
      end
   endtask

   initial begin
      resetn_i = 1'b0; req_i = 1'b0; instr_i = '0; rs1_rdata_i = '0;
      lane_mask_rdata_i = '0; clr_req = 1'b0;
      for (int i = 0; i < N; i++) begin vs1_mem[i] = '0; vs2_mem[i] = 32'(100 + i); end
      repeat (2) @(negedge clk_i);
      check("rst_ready",  32'(ready_o), 32'd1);
      check("rst_vd_we",  32'(lane_vd_wr_en_o), 32'd0);
      check("rst_rd_we",  32'(rd_wr_en_o), 32'd0);
      check("rst_rd_dat", rd_wdata_o, 32'd0);
      check("rst_vd_dat", 32'(|lane_vd_wdata_o), 32'd0);
      check("rst_sel",    32'({lane_vs2_elem_sel_o, lane_vd_elem_sel_o}), 32'd0);
      resetn_i = 1'b1;

      // vslideup.vx off=3, mask ignored with vm=1
      clear_vd();
      run_op(mk(6'b001110, 1'b1, 3'b100, 5'd1), 32'd3);
      check("up3_busy", 32'(busy), 32'd4);
      for (int i = 0; i < N; i++)
         check($sformatf("up3_vd%0d", i), vd_mem[i], (i < 3) ? sent(i) : 32'(100 + i - 3));

      // vslidedown.vi imm=5
      clear_vd();
      run_op(mk(6'b001111, 1'b1, 3'b011, 5'd5), 32'd5);
      check("dn5_busy", 32'(busy), 32'd4);
      for (int i = 0; i < N; i++)
         check($sformatf("dn5_vd%0d", i), vd_mem[i], (i <= 10) ? 32'(105 + i) : 32'd0);

      // masked vslideup off=0: odd indices only
      clear_vd();
      lane_mask_rdata_i = 32'h0000AAAA;
      run_op(mk(6'b001110, 1'b0, 3'b100, 5'd1), 32'd0);
      lane_mask_rdata_i = '0;
      for (int i = 0; i < N; i++)
         check($sformatf("mup_vd%0d", i), vd_mem[i], (i % 2 == 1) ? 32'(100 + i) : sent(i));

      // off >= VLMAX boundaries
      clear_vd();
      run_op(mk(6'b001110, 1'b1, 3'b100, 5'd1), 32'd16);
      check("up16_vd0",  vd_mem[0],  sent(0));
      check("up16_vd15", vd_mem[15], sent(15));
      run_op(mk(6'b001111, 1'b1, 3'b100, 5'd1), 32'd20);
      check("dn20_vd0",  vd_mem[0],  32'd0);
      check("dn20_vd15", vd_mem[15], 32'd0);

      // vredsum.vs
      clear_vd();
      for (int i = 0; i < N; i++) vs2_mem[i] = 32'(i);
      vs1_mem[0] = 32'd10;
      run_op(mk(6'b000000, 1'b1, 3'b010, 5'd1), 32'd0);
      check("sum_busy", 32'(busy), 32'd5);
      check("sum_vd0",  vd_mem[0],  32'd130);
      check("sum_vd1",  vd_mem[1],  sent(1));
      check("sum_vd15", vd_mem[15], sent(15));

      // signed/unsigned max and min on {vs1=-5, vs2[7]=-1, rest 0}
      for (int i = 0; i < N; i++) vs2_mem[i] = '0;
      vs2_mem[7] = 32'hFFFFFFFF;
      vs1_mem[0] = 32'hFFFFFFFB;
      run_op(mk(6'b000111, 1'b1, 3'b010, 5'd1), 32'd0);
      check("max_vd0",  vd_mem[0], 32'd0);
      run_op(mk(6'b000110, 1'b1, 3'b010, 5'd1), 32'd0);
      check("maxu_vd0", vd_mem[0], 32'hFFFFFFFF);
      run_op(mk(6'b000101, 1'b1, 3'b010, 5'd1), 32'd0);
      check("min_vd0",  vd_mem[0], 32'hFFFFFFFB);

      // vmv.x.s / vmv.s.x
      vs2_mem[0] = 32'hDEADBEEF;
      run_op(mk(6'b010000, 1'b1, 3'b010, 5'd0), 32'd0);
      check("mvxs_busy", 32'(busy), 32'd1);
      check("mvxs_cnt",  32'(rd_cnt), 32'd1);
      check("mvxs_dat",  rd_val, 32'hDEADBEEF);
      clear_vd();
      run_op(mk(6'b010000, 1'b1, 3'b110, 5'd1), 32'h12345678);
      check("mvsx_busy", 32'(busy), 32'd1);
      check("mvsx_vd0",  vd_mem[0], 32'h12345678);
      check("mvsx_vd4",  vd_mem[4], sent(4));

      // unsupported encoding: one cycle, no writes
      clear_vd();
      run_op(mk(6'b111111, 1'b1, 3'b000, 5'd1), 32'd0);
      check("nop_busy", 32'(busy), 32'd1);
      check("nop_vd0",  vd_mem[0], sent(0));

      // reset in the middle of a slide
      @(negedge clk_i);
      instr_i = mk(6'b001110, 1'b1, 3'b100, 5'd1); rs1_rdata_i = '0; req_i = 1'b1;
      @(posedge clk_i);
      #1 req_i = 1'b0;
      @(negedge clk_i);
      check("abort_pre_we", 32'(lane_vd_wr_en_o), 32'hF);
      resetn_i = 1'b0;
      #1;
      check("abort_we",    32'(lane_vd_wr_en_o), 32'd0);
      check("abort_ready", 32'(ready_o), 32'd1);
      @(negedge clk_i) resetn_i = 1'b1;
      @(negedge clk_i);
      check("abort_idle", 32'(ready_o), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
